// File: rtl/timer0_engine.sv
// timer0_engine: 8051 Timer 0 counting engine producing registered TH0/TL0 write-backs and TF pulses.
module timer0_engine #(
  parameter int CLK_DIV = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0_pin,
  input  logic       i_t0_pin,
  input  logic [7:0] i_tl0,
  input  logic [7:0] i_th0,
  input  logic       i_cpu_wr_tl0,
  input  logic       i_cpu_wr_th0,
  output logic [7:0] o_tl0_next,
  output logic [7:0] o_th0_next,
  output logic       o_wr_tl0,
  output logic       o_wr_th0,
  output logic       o_tf0_set,
  output logic       o_tf1_set
);
  logic [7:0]  presc_q, presc_d;
  logic        int0_s1_q, int0_s2_q, t0_s1_q, t0_s2_q, t0_prev_q;
  logic        edge_latch_q, edge_latch_d;
  logic [7:0]  tl_next_q, tl_next_d, th_next_q, th_next_d;
  logic        wr_tl_q, wr_tl_d, wr_th_q, wr_th_d, tf0_q, tf0_d, tf1_q, tf1_d;
  logic        tick, edge_now, run0, ev0, ev1, th_ev, wrap0;
  logic [12:0] c13;
  logic [15:0] c16;
  logic [7:0]  tl_inc, th_inc, tl_new, th_new;
  logic [1:0]  mode;

  assign mode     = i_tmod[1:0];
  assign tick     = presc_q == 8'(CLK_DIV - 1);
  assign presc_d  = tick ? 8'd0 : presc_q + 8'd1;
  assign edge_now = t0_prev_q & ~t0_s2_q;
  assign run0     = i_tr0 & (~i_tmod[3] | int0_s2_q);
  assign ev0      = tick & run0 & (~i_tmod[2] | edge_latch_q | edge_now);
  assign ev1      = tick & i_tr1 & (mode == 2'd3);
  assign c13      = {i_th0, i_tl0[4:0]} + 13'd1;
  assign c16      = {i_th0, i_tl0} + 16'd1;
  assign tl_inc   = i_tl0 + 8'd1;
  assign th_inc   = i_th0 + 8'd1;
  // an edge seen in the tick cycle itself is consumed by that tick
  assign edge_latch_d = tick ? 1'b0 : (edge_latch_q | edge_now);

  always_comb begin
    tl_new = tl_inc;
    th_new = th_inc;
    wrap0  = &i_tl0;
    th_ev  = 1'b0;
    case (mode)
      2'd0: begin
        tl_new = {i_tl0[7:5], c13[4:0]};
        th_new = c13[12:5];
        wrap0  = &{i_th0, i_tl0[4:0]};
        th_ev  = ev0;
      end
      2'd1: begin
        {th_new, tl_new} = c16;
        wrap0 = &{i_th0, i_tl0};
        th_ev = ev0;
      end
      2'd2: tl_new = (&i_tl0) ? i_th0 : tl_inc;
      default: th_ev = ev1;
    endcase
  end

  assign tl_next_d = ev0 ? tl_new : tl_next_q;
  assign th_next_d = th_ev ? th_new : th_next_q;
  assign wr_tl_d   = ev0 & ~i_cpu_wr_tl0;
  assign wr_th_d   = th_ev & ~i_cpu_wr_th0;
  assign tf0_d     = ev0 & wrap0;
  assign tf1_d     = ev1 & (&i_th0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      presc_q      <= 8'd0;
      int0_s1_q    <= 1'b1;
      int0_s2_q    <= 1'b1;
      t0_s1_q      <= 1'b1;
      t0_s2_q      <= 1'b1;
      t0_prev_q    <= 1'b1;
      edge_latch_q <= 1'b0;
      tl_next_q    <= 8'd0;
      th_next_q    <= 8'd0;
      wr_tl_q      <= 1'b0;
      wr_th_q      <= 1'b0;
      tf0_q        <= 1'b0;
      tf1_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      int0_s1_q    <= i_int0_pin;
      int0_s2_q    <= int0_s1_q;
      t0_s1_q      <= i_t0_pin;
      t0_s2_q      <= t0_s1_q;
      t0_prev_q    <= t0_s2_q;
      edge_latch_q <= edge_latch_d;
      tl_next_q    <= tl_next_d;
      th_next_q    <= th_next_d;
      wr_tl_q      <= wr_tl_d;
      wr_th_q      <= wr_th_d;
      tf0_q        <= tf0_d;
      tf1_q        <= tf1_d;
    end
  end

  // a CPU write landing in the strobe cycle still wins over the engine
  assign o_wr_tl0   = wr_tl_q & ~i_cpu_wr_tl0;
  assign o_wr_th0   = wr_th_q & ~i_cpu_wr_th0;
  assign o_tl0_next = tl_next_q;
  assign o_th0_next = th_next_q;
  assign o_tf0_set  = tf0_q;
  assign o_tf1_set  = tf1_q;
endmodule

// File: tb/tb_timer0_engine.sv
// tb_timer0_engine: vector table plus pin sequences; expectations queued at each tick, compared in the strobe cycle.
module tb_timer0_engine;
  localparam int CLK_DIV = 12;
  logic       i_clk = 1'b0, i_rst = 1'b0;
  logic [3:0] i_tmod = 4'd0;
  logic       i_tr0 = 1'b0, i_tr1 = 1'b0, i_int0_pin = 1'b1, i_t0_pin = 1'b1;
  logic [7:0] i_tl0 = 8'd0, i_th0 = 8'd0;
  logic       i_cpu_wr_tl0 = 1'b0, i_cpu_wr_th0 = 1'b0;
  logic [7:0] o_tl0_next, o_th0_next;
  logic       o_wr_tl0, o_wr_th0, o_tf0_set, o_tf1_set;
  int         errors = 0, checks = 0;
  int         tb_presc;

  typedef struct {
    logic [3:0] tmod;
    logic       tr0, tr1;
    logic [7:0] tl, th;
    logic [3:0] cw;
    logic       e_wtl, e_wth, e_tf0, e_tf1;
    logic [7:0] e_tl, e_th;
  } vec_t;
  typedef struct {
    logic       wtl, wth, tf0, tf1;
    logic [7:0] tl, th;
    int         id;
  } exp_t;
  exp_t q[$];
  vec_t vt[14];

  timer0_engine #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tmod(i_tmod), .i_tr0(i_tr0), .i_tr1(i_tr1),
    .i_int0_pin(i_int0_pin), .i_t0_pin(i_t0_pin), .i_tl0(i_tl0), .i_th0(i_th0),
    .i_cpu_wr_tl0(i_cpu_wr_tl0), .i_cpu_wr_th0(i_cpu_wr_th0),
    .o_tl0_next(o_tl0_next), .o_th0_next(o_th0_next), .o_wr_tl0(o_wr_tl0),
    .o_wr_th0(o_wr_th0), .o_tf0_set(o_tf0_set), .o_tf1_set(o_tf1_set)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst)
    if (!i_rst) tb_presc <= 0;
    else tb_presc <= (tb_presc == CLK_DIV - 1) ? 0 : tb_presc + 1;

  task automatic check(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge i_clk) if (i_rst) begin
    if (tb_presc == 0 && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("v%0d_wr_tl0", e.id), 16'(o_wr_tl0), 16'(e.wtl));
      check($sformatf("v%0d_wr_th0", e.id), 16'(o_wr_th0), 16'(e.wth));
      check($sformatf("v%0d_tf0", e.id), 16'(o_tf0_set), 16'(e.tf0));
      check($sformatf("v%0d_tf1", e.id), 16'(o_tf1_set), 16'(e.tf1));
      if (e.wtl) check($sformatf("v%0d_tl0_next", e.id), 16'(o_tl0_next), 16'(e.tl));
      if (e.wth) check($sformatf("v%0d_th0_next", e.id), 16'(o_th0_next), 16'(e.th));
    end else
      check("idle_strobes", 16'({o_wr_tl0, o_wr_th0, o_tf0_set, o_tf1_set}), 16'd0);
  end

  function automatic vec_t mk(input logic [3:0] tmod, input logic tr0, tr1, input logic [7:0] tl, th,
                              input logic [3:0] cw, input logic e_wtl, e_wth, input logic [7:0] e_tl, e_th,
                              input logic e_tf0, e_tf1);
    vec_t v;
    v.tmod = tmod; v.tr0 = tr0; v.tr1 = tr1; v.tl = tl; v.th = th; v.cw = cw;
    v.e_wtl = e_wtl; v.e_wth = e_wth; v.e_tl = e_tl; v.e_th = e_th; v.e_tf0 = e_tf0; v.e_tf1 = e_tf1;
    return v;
  endfunction

  task automatic wait_presc(input int p);
    do @(negedge i_clk); while (tb_presc != p);
  endtask

  task automatic do_vec(input int id, input vec_t v);
    exp_t e;
    wait_presc(CLK_DIV - 1);
    i_tmod = v.tmod; i_tr0 = v.tr0; i_tr1 = v.tr1; i_tl0 = v.tl; i_th0 = v.th;
    i_cpu_wr_tl0 = v.cw[3]; i_cpu_wr_th0 = v.cw[2];
    e.wtl = v.e_wtl; e.wth = v.e_wth; e.tf0 = v.e_tf0; e.tf1 = v.e_tf1;
    e.tl = v.e_tl; e.th = v.e_th; e.id = id;
    q.push_back(e);
    @(posedge i_clk); #1;
    i_cpu_wr_tl0 = v.cw[1]; i_cpu_wr_th0 = v.cw[0]; i_tr0 = 1'b0; i_tr1 = 1'b0;
    @(posedge i_clk); #1;
    i_cpu_wr_tl0 = 1'b0; i_cpu_wr_th0 = 1'b0;
  endtask

  task automatic ct_cycle(input int id, input int fall_at, input int rise_at, input bit cnt);
    exp_t e;
    wait_presc(0);
    for (int k = 0; k < CLK_DIV; k++) begin
      if (k == fall_at) i_t0_pin = 1'b0;
      if (k == rise_at) i_t0_pin = 1'b1;
      if (k == CLK_DIV - 1 && cnt) begin
        e.wtl = 1'b1; e.wth = 1'b1; e.tf0 = 1'b0; e.tf1 = 1'b0;
        e.tl = i_tl0 + 8'd1; e.th = i_th0; e.id = id;
        q.push_back(e);
      end
      if (k < CLK_DIV - 1) @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    if (cnt) i_tl0 = i_tl0 + 8'd1;
  endtask

  initial begin
    vt[0]  = mk(4'b0001, 1, 0, 8'hFE, 8'h12, 4'b0000, 1, 1, 8'hFF, 8'h12, 0, 0);
    vt[1]  = mk(4'b0001, 1, 0, 8'hFF, 8'h12, 4'b0000, 1, 1, 8'h00, 8'h13, 0, 0);
    vt[2]  = mk(4'b0001, 1, 0, 8'hFF, 8'hFF, 4'b0000, 1, 1, 8'h00, 8'h00, 1, 0);
    vt[3]  = mk(4'b0010, 1, 0, 8'hFF, 8'hA0, 4'b0000, 1, 0, 8'hA0, 8'h00, 1, 0);
    vt[4]  = mk(4'b0010, 1, 0, 8'h05, 8'hA0, 4'b0000, 1, 0, 8'h06, 8'h00, 0, 0);
    vt[5]  = mk(4'b0000, 1, 0, 8'hFF, 8'hFF, 4'b0000, 1, 1, 8'hE0, 8'h00, 1, 0);
    vt[6]  = mk(4'b0000, 1, 0, 8'h3F, 8'h34, 4'b0000, 1, 1, 8'h20, 8'h35, 0, 0);
    vt[7]  = mk(4'b0011, 0, 1, 8'h55, 8'hFF, 4'b0000, 0, 1, 8'h00, 8'h00, 0, 1);
    vt[8]  = mk(4'b0011, 1, 1, 8'hFF, 8'h10, 4'b0000, 1, 1, 8'h00, 8'h11, 1, 0);
    vt[9]  = mk(4'b0011, 0, 1, 8'h55, 8'hFF, 4'b0100, 0, 0, 8'h00, 8'h00, 0, 1);
    vt[10] = mk(4'b0001, 1, 0, 8'h10, 8'h00, 4'b0010, 0, 1, 8'h00, 8'h00, 0, 0);
    vt[11] = mk(4'b0001, 0, 0, 8'h10, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 0, 0);
    vt[12] = mk(4'b1001, 1, 0, 8'h00, 8'h00, 4'b0000, 1, 1, 8'h01, 8'h00, 0, 0);
    vt[13] = mk(4'b0001, 1, 0, 8'hFF, 8'hFF, 4'b1000, 0, 1, 8'h00, 8'h00, 1, 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_strobes", 16'({o_wr_tl0, o_wr_th0, o_tf0_set, o_tf1_set}), 16'd0);
    check("rst_values", {o_th0_next, o_tl0_next}, 16'd0);
    #1 i_rst = 1'b1;
    for (int i = 0; i < 14; i++) do_vec(i, vt[i]);
    i_tmod = 4'b1101; i_tr0 = 1'b1; i_int0_pin = 1'b0; i_tl0 = 8'h10; i_th0 = 8'h00;
    repeat (5) ct_cycle(100, 1, 5, 0);
    i_int0_pin = 1'b1;
    for (int i = 0; i < 3; i++) ct_cycle(101 + i, 1, 5, 1);
    ct_cycle(104, 1, -1, 1);
    repeat (2) ct_cycle(105, -1, -1, 0);
    ct_cycle(106, -1, 2, 0);
    ct_cycle(107, 9, -1, 1);
    ct_cycle(108, -1, 3, 0);
    check("ct_tl0_total", 16'(i_tl0), 16'h15);
    i_tr0 = 1'b0;
    wait_presc(CLK_DIV - 1);
    i_tmod = 4'b0001; i_tr0 = 1'b1; i_tl0 = 8'h00; i_th0 = 8'h00;
    @(posedge i_clk); #1;
    i_tr0 = 1'b0;
    check("pre_rst_wr_tl0", 16'(o_wr_tl0), 16'd1);
    #1 i_rst = 1'b0;
    #1;
    check("midrst_strobes", 16'({o_wr_tl0, o_wr_th0, o_tf0_set, o_tf1_set}), 16'd0);
    check("midrst_values", {o_th0_next, o_tl0_next}, 16'd0);
    repeat (2) @(negedge i_clk);
    #1 i_rst = 1'b1;
    do_vec(200, vt[0]);
    repeat (CLK_DIV + 2) @(posedge i_clk);
    check("sb_empty", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
